// File: rtl/shift_rotate_pkg.sv
// Shared types and constants for the shift/rotate arbiter slice.
package shift_rotate_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;

  localparam logic DIR_LEFT    = 1'b0;
  localparam logic DIR_RIGHT   = 1'b1;
  localparam logic TYPE_SHIFT  = 1'b0;
  localparam logic TYPE_ROTATE = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amount;
    logic              dir;
    logic              typ;
  } sr_op_t;

endpackage

// File: rtl/shift_rotate.sv
// Purely combinational 32-bit logical shift / rotate unit.
module shift_rotate
  import shift_rotate_pkg::*;
(
  input  sr_op_t            op,
  output logic [DATA_W-1:0] result_c
);

  logic [2*DATA_W-1:0] dbl;
  logic [DATA_W-1:0]   shl;
  logic [DATA_W-1:0]   shr;
  logic [DATA_W-1:0]   rotl;
  logic [DATA_W-1:0]   rotr;

  // Rotates take a window out of the operand concatenated with itself
  always_comb begin
    dbl  = {op.data, op.data};
    shl  = op.data << op.amount;
    shr  = op.data >> op.amount;
    rotl = DATA_W'(dbl >> (DATA_W - 32'(op.amount)));
    rotr = DATA_W'(dbl >> op.amount);
    result_c = shl;
    if (op.typ == TYPE_SHIFT) begin
      result_c = (op.dir == DIR_LEFT) ? shl : shr;
    end else if (op.typ == TYPE_ROTATE) begin
      result_c = (op.dir == DIR_RIGHT) ? rotr : rotl;
    end
  end

endmodule

// File: rtl/shift_rotate_arbiter_rr_arb.sv
// Rotating-priority grant: first valid requester at or after ptr, wrapping.
module shift_rotate_rr_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [ID_W-1:0]    grant_id_c,
  output logic               grant_valid_c
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant_c       = '0;
    grant_id_c    = '0;
    grant_valid_c = 1'b0;
    idx           = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = ID_W'((32'(ptr) + off) % NUM_REQ);
      if (!grant_valid_c && req_valid[idx]) begin
        grant_valid_c = 1'b1;
        grant_id_c    = idx;
        grant_c[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_rotate_arbiter.sv
// Round-robin sharing of one shift/rotate unit across NUM_REQ requesters,
// with a one-entry tagged response register drained under backpressure.
module shift_rotate_arbiter
  import shift_rotate_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*AMT_W-1:0]  req_amount,
  input  logic [NUM_REQ-1:0]        req_dir,
  input  logic [NUM_REQ-1:0]        req_type,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id
);

  out_state_e        state_q;
  out_state_e        state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   grant_id;
  logic              grant_valid;
  logic              can_accept;
  logic              xfer;
  sr_op_t            op_sel;
  logic [DATA_W-1:0] sr_result;
  logic [DATA_W-1:0] rsp_data_q;
  logic [ID_W-1:0]   rsp_id_q;

  shift_rotate_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_valid     (req_valid),
    .ptr           (ptr_q),
    .grant_c       (grant),
    .grant_id_c    (grant_id),
    .grant_valid_c (grant_valid)
  );

  // Output-stage state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; reset blocks acceptance so nothing is handshaken during rst
  always_comb begin
    state_d    = state_q;
    can_accept = 1'b0;
    xfer       = 1'b0;
    case (state_q)
      EMPTY:   can_accept = !rst;
      FULL:    can_accept = rsp_ready && !rst;
      default: can_accept = 1'b0;
    endcase
    xfer = grant_valid && can_accept;
    if (xfer) begin
      state_d = FULL;
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  assign req_ready = grant & {NUM_REQ{can_accept}};

  // Select the granted requester's payload
  always_comb begin
    op_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        op_sel.data   = req_data[DATA_W*i +: DATA_W];
        op_sel.amount = req_amount[AMT_W*i +: AMT_W];
        op_sel.dir    = req_dir[i];
        op_sel.typ    = req_type[i];
      end
    end
  end

  shift_rotate u_shift_rotate (
    .op       (op_sel),
    .result_c (sr_result)
  );

  // Result register, tag and round-robin pointer advance on each transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else if (xfer) begin
      rsp_data_q <= sr_result;
      rsp_id_q   <= grant_id;
      ptr_q      <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: doc/shift_rotate_arbiter.md
# shift_rotate_arbiter

Shares one 32-bit ShiftRotate datapath between NUM_REQ independent requesters. Each requester presents an operation (data, amount, direction, type) on a valid/ready channel. A round-robin arbiter grants one operation per cycle into the shared ShiftRotate. The result is registered in a one-entry output stage, tagged with the requester index, and drained through a valid/ready response channel with backpressure.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- ID_W, $clog2(NUM_REQ), width of the response tag
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or all-zero
- req_data  in  NUM_REQ*32  operand; slice i is bits [32*i +: 32]
- req_amount  in  NUM_REQ*5  shift/rotate amount, 0..31
- req_dir  in  NUM_REQ  0 = left, 1 = right
- req_type  in  NUM_REQ  0 = logical shift (zero fill), 1 = rotate
- rsp_valid  out  1  result held in output register
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  32  shifted/rotated result
- rsp_id  out  ID_W  index of the requester that issued the operation

## Operation
- **Output stage FSM.** Two states, EMPTY and FULL. rsp_valid = (state == FULL).
  - can_accept = EMPTY, or (FULL and rsp_ready).
- **Arbitration.**
  - Round-robin pointer ptr (ID_W bits).
  - Grant g is the first i with req_valid[i] set, searching ptr, ptr+1, … modulo NUM_REQ.
  - req_ready[g] = can_accept. All other req_ready bits are 0.
- **Transfer.** A transfer occurs on req_valid[g] & req_ready[g]. On transfer:
  - Slice g drives ShiftRotate.
  - The ShiftRotate output is captured into rsp_data, and g into rsp_id.
  - state becomes FULL.
  - ptr becomes (g+1) mod NUM_REQ.
- **Draining.** FULL & rsp_ready with no transfer returns to EMPTY. FULL & rsp_ready with a transfer stays FULL with the new result.
- **Hold.** FULL & !rsp_ready: rsp_data and rsp_id are held stable, and all req_ready bits are 0.
- **Arithmetic.**
  - Shift left: data << amt. Shift right: logical data >> amt.
  - Rotate wraps modulo 32.
  - amt = 0 passes data unchanged.
  - Amount is 5 bits, so no out-of-range values exist.
- **Requester obligation.** Hold valid and payload stable until accepted. The arbiter never drops or duplicates an accepted operation.
- **Fairness.** A continuously valid requester is granted within NUM_REQ transfers.

## Timing
- **Reset values.** state = EMPTY, ptr = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, req_ready = 0.
- **Reset mid-operation.** A held result is discarded and rsp_valid is 0 in the cycle after rst is sampled high. A request asserted during rst is not accepted.
- **Latency.** Accept at cycle N gives rsp_valid at N+1.
- **Throughput.** One operation per cycle while rsp_ready = 1.
- **Path.** req_ready is combinational from req_valid, ptr, state and rsp_ready. No combinational path runs from req_* to rsp_*.
- **Simultaneous events.** Drain and accept in the same cycle keep rsp_valid high with no bubble.
- **Idle.** No valid requests: ptr is unchanged.

## Structure
- **Package shift_rotate_pkg:**
  - DATA_W = 32, AMT_W = 5
  - DIR_LEFT = 0, DIR_RIGHT = 1
  - TYPE_SHIFT = 0, TYPE_ROTATE = 1
  - output-stage state enum {EMPTY, FULL}
- **Sub-modules:**
  - Existing ShiftRotate, instantiated once, purely combinational.
  - One new sub-module, shift_rotate_rr_arb: NUM_REQ-wide rotating-priority grant from req_valid and ptr, returning a one-hot grant and the encoded index.
- **Target size.** 150–250 lines of RTL total.

## Test plan
- **Single request.** Requester 1: data A5A5A5A5, amt 4, left shift → next cycle rsp_valid = 1, rsp_data = 5A5A5A50, rsp_id = 1. With dir = right and type = rotate → 5A5A5A5A.
- **Round-robin.** All 4 requesters valid continuously with rsp_ready = 1 → rsp_id sequence 0,1,2,3,0,1, with rsp_valid high every cycle after the first.
- **Backpressure.** With FULL, hold rsp_ready = 0 for 3 cycles → rsp_data and rsp_id stable, req_ready = 0000. Raise rsp_ready → the next grant is accepted in the same cycle.
- **Boundary amounts.**
  - CAFEBABE, shift right by 31 → 00000001.
  - CAFEBABE, rotate left by 0 → CAFEBABE.
  - DEADBEEF, rotate left by 8 → ADBEEFDE.
  - FFFFFFFF, shift left by 31 → 80000000.
- **Reset mid-operation.** rst = 1 while FULL and requests pending → next cycle rsp_valid = 0 and ptr = 0. After rst falls, requester 0 wins over requester 2 when both are valid.
- **Scoreboard.** Random payloads and valids over 500 cycles with random rsp_ready, checked against a reference model → every accepted operation is returned exactly once, in order, with the correct tag.
